// File: rtl/raster_pkg.sv
// Shared types and default geometry for the rasterizer back end.
package raster_pkg;

  localparam int DFLT_FB_WIDTH  = 160;
  localparam int DFLT_FB_HEIGHT = 120;
  localparam int FB_ADDRW       = $clog2(DFLT_FB_WIDTH * DFLT_FB_HEIGHT);
  localparam int DEPTH_WIDTH    = 12;
  localparam int COLR_WIDTH     = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  typedef struct packed {
    logic [FB_ADDRW-1:0]    addr;
    logic [DEPTH_WIDTH-1:0] depth;
    logic [COLR_WIDTH-1:0]  colr;
  } frag_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/depth_test_writer_if.sv
// Fragment stream, clear control and buffer write-side signals of the depth test writer.
interface depth_test_writer_if;
  import raster_pkg::*;

  logic                   frag_valid;
  logic                   frag_ready;
  logic [FB_ADDRW-1:0]    frag_addr;
  logic [DEPTH_WIDTH-1:0] frag_depth;
  logic [COLR_WIDTH-1:0]  frag_colr;
  logic                   clear_start;
  logic                   clear_busy;
  logic                   clear_done;
  logic [FB_ADDRW-1:0]    db_addr_read;
  logic [DEPTH_WIDTH-1:0] db_data_read;
  logic [FB_ADDRW-1:0]    db_addr_write;
  logic [DEPTH_WIDTH-1:0] db_data_write;
  logic                   db_write_enable;
  logic [FB_ADDRW-1:0]    fb_addr_write;
  logic [COLR_WIDTH-1:0]  fb_data_write;
  logic                   fb_write_enable;
  logic [31:0]            pass_count;
  logic [31:0]            fail_count;

  modport master (
    output frag_valid, frag_addr, frag_depth, frag_colr, clear_start, db_data_read,
    input  frag_ready, clear_busy, clear_done, db_addr_read, db_addr_write, db_data_write,
           db_write_enable, fb_addr_write, fb_data_write, fb_write_enable, pass_count, fail_count
  );

  modport slave (
    input  frag_valid, frag_addr, frag_depth, frag_colr, clear_start, db_data_read,
    output frag_ready, clear_busy, clear_done, db_addr_read, db_addr_write, db_data_write,
           db_write_enable, fb_addr_write, fb_data_write, fb_write_enable, pass_count, fail_count
  );

endinterface

// File: rtl/depth_forward_unit.sv
// Picks the freshest stored depth (W1, then W2, then RAM) and runs the LESS test; purely combinational.
module depth_forward_unit
  import raster_pkg::*;
(
  input  logic [FB_ADDRW-1:0]    i_addr,
  input  logic [DEPTH_WIDTH-1:0] i_depth,
  input  logic [DEPTH_WIDTH-1:0] i_ram_depth,
  input  logic                   i_w1_hit,
  input  logic [FB_ADDRW-1:0]    i_w1_addr,
  input  logic [DEPTH_WIDTH-1:0] i_w1_depth,
  input  logic                   i_w2_hit,
  input  logic [FB_ADDRW-1:0]    i_w2_addr,
  input  logic [DEPTH_WIDTH-1:0] i_w2_depth,
  output logic                   o_pass
);

  logic [DEPTH_WIDTH-1:0] w_eff_depth;

  // W1 is applied last so it overrides an older W2 match on the same pixel.
  always_comb begin
    w_eff_depth = i_ram_depth;
    if (i_w2_hit && (i_w2_addr == i_addr)) w_eff_depth = i_w2_depth;
    if (i_w1_hit && (i_w1_addr == i_addr)) w_eff_depth = i_w1_depth;
  end

  assign o_pass = (i_depth < w_eff_depth);

endmodule

// File: rtl/depth_test_writer.sv
// Depth-tests fragments (1/cycle, write strobes 2 cycles after accept) and clears both buffers on request.
// frag_ready drops while a clear is requested, draining or running; there is no downstream backpressure.
module depth_test_writer
  import raster_pkg::*;
#(
  parameter int                     FB_WIDTH    = DFLT_FB_WIDTH,
  parameter int                     FB_HEIGHT   = DFLT_FB_HEIGHT,
  parameter logic [DEPTH_WIDTH-1:0] CLEAR_DEPTH = DEPTH_WIDTH'(4095),
  parameter logic [COLR_WIDTH-1:0]  CLEAR_COLR  = COLR_WIDTH'(0)
) (
  input  logic               clk,
  input  logic               rst,
  depth_test_writer_if.slave dtw
);

  localparam int                PIXELS    = FB_WIDTH * FB_HEIGHT;
  localparam logic [FB_ADDRW:0] LAST_ADDR = (FB_ADDRW + 1)'(PIXELS - 1);

  state_t                 r_state;
  frag_t                  r_s1;
  logic                   r_s1_vld;
  logic                   r_w1_vld;
  logic                   r_w1_hit;
  logic [FB_ADDRW-1:0]    r_w1_addr;
  logic [DEPTH_WIDTH-1:0] r_w1_depth;
  logic                   r_w2_hit;
  logic [FB_ADDRW-1:0]    r_w2_addr;
  logic [DEPTH_WIDTH-1:0] r_w2_depth;
  logic [FB_ADDRW:0]      r_clr_addr;
  logic                   r_busy;
  logic                   r_done;
  logic [FB_ADDRW-1:0]    r_wr_addr;
  logic [DEPTH_WIDTH-1:0] r_db_data;
  logic [COLR_WIDTH-1:0]  r_fb_data;
  logic                   r_we;
  logic [31:0]            r_pass_cnt;
  logic [31:0]            r_fail_cnt;

  logic  w_frag_ready;
  logic  w_accept;
  logic  w_pass;
  frag_t w_frag;

  assign w_frag_ready = (r_state == ST_RUN) && !dtw.clear_start;
  assign w_accept     = dtw.frag_valid && w_frag_ready;
  assign w_frag       = {dtw.frag_addr, dtw.frag_depth, dtw.frag_colr};

  assign dtw.frag_ready      = w_frag_ready;
  assign dtw.db_addr_read    = dtw.frag_addr;
  assign dtw.clear_busy      = r_busy;
  assign dtw.clear_done      = r_done;
  assign dtw.db_addr_write   = r_wr_addr;
  assign dtw.db_data_write   = r_db_data;
  assign dtw.db_write_enable = r_we;
  assign dtw.fb_addr_write   = r_wr_addr;
  assign dtw.fb_data_write   = r_fb_data;
  assign dtw.fb_write_enable = r_we;
  assign dtw.pass_count      = r_pass_cnt;
  assign dtw.fail_count      = r_fail_cnt;

  depth_forward_unit u_fwd (
    .i_addr      (r_s1.addr),
    .i_depth     (r_s1.depth),
    .i_ram_depth (dtw.db_data_read),
    .i_w1_hit    (r_w1_hit),
    .i_w1_addr   (r_w1_addr),
    .i_w1_depth  (r_w1_depth),
    .i_w2_hit    (r_w2_hit),
    .i_w2_addr   (r_w2_addr),
    .i_w2_depth  (r_w2_depth),
    .o_pass      (w_pass)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_s1       <= '0;
      r_s1_vld   <= 1'b0;
      r_w1_vld   <= 1'b0;
      r_w1_hit   <= 1'b0;
      r_w1_addr  <= '0;
      r_w1_depth <= '0;
      r_w2_hit   <= 1'b0;
      r_w2_addr  <= '0;
      r_w2_depth <= '0;
      r_clr_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_addr  <= '0;
      r_db_data  <= '0;
      r_fb_data  <= '0;
      r_we       <= 1'b0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_done     <= 1'b0;
      r_we       <= 1'b0;
      r_s1_vld   <= w_accept;
      if (w_accept) r_s1 <= w_frag;
      r_w1_vld   <= r_s1_vld;
      r_w1_hit   <= r_s1_vld && w_pass;
      r_w1_addr  <= r_s1.addr;
      r_w1_depth <= r_s1.depth;
      r_w2_hit   <= r_w1_hit;
      r_w2_addr  <= r_w1_addr;
      r_w2_depth <= r_w1_depth;

      if (r_s1_vld) begin
        if (w_pass) begin
          r_we       <= 1'b1;
          r_wr_addr  <= r_s1.addr;
          r_db_data  <= r_s1.depth;
          r_fb_data  <= r_s1.colr;
          r_pass_cnt <= sat_inc(r_pass_cnt);
        end else begin
          r_fail_cnt <= sat_inc(r_fail_cnt);
        end
      end

      case (r_state)
        ST_RUN: begin
          if (dtw.clear_start) begin
            r_busy     <= 1'b1;
            r_clr_addr <= '0;
            r_state    <= (r_s1_vld || r_w1_vld) ? ST_DRAIN : ST_CLEAR;
          end
        end
        ST_DRAIN: begin
          if (!r_s1_vld && !r_w1_vld) r_state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          // One spare cycle after the last write so a fragment accepted on return reads cleared data.
          if (r_clr_addr <= LAST_ADDR) begin
            r_we       <= 1'b1;
            r_wr_addr  <= r_clr_addr[FB_ADDRW-1:0];
            r_db_data  <= CLEAR_DEPTH;
            r_fb_data  <= CLEAR_COLR;
            r_clr_addr <= r_clr_addr + 1'b1;
            if (r_clr_addr == LAST_ADDR) begin
              r_done     <= 1'b1;
              r_pass_cnt <= '0;
              r_fail_cnt <= '0;
              r_w1_vld   <= 1'b0;
              r_w1_hit   <= 1'b0;
              r_w2_hit   <= 1'b0;
            end
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_depth_test_writer.sv
// Directed plus random fragment traffic against a sequential golden depth buffer, with buffer clears and reset.
module tb_depth_test_writer;
  import raster_pkg::*;

  localparam int PIX = DFLT_FB_WIDTH * DFLT_FB_HEIGHT;

  typedef struct {
    int cyc;
    int addr;
    int depth;
    int colr;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  depth_test_writer_if bus();
  depth_test_writer dut (.clk(clk), .rst(rst), .dtw(bus));

  logic [DEPTH_WIDTH-1:0] db_mem [PIX];
  always @(posedge clk) begin
    bus.db_data_read <= db_mem[bus.db_addr_read];
    if (bus.db_write_enable) db_mem[bus.db_addr_write] <= bus.db_data_write;
  end

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  wr_t exp_wr[$];
  int  gdepth[PIX];
  int  exp_pass = 0;
  int  exp_fail = 0;
  bit  in_clear = 1'b0;
  int  clr_writes, clr_bad, clr_next, clr_done_seen, clr_done_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    wr_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc) begin
      e = exp_wr.pop_front();
      check("frag_write_strobes", {62'd0, bus.db_write_enable, bus.fb_write_enable}, 64'd3);
      check("frag_write_data",
            {18'd0, bus.db_addr_write, bus.fb_addr_write, bus.db_data_write, bus.fb_data_write},
            {18'd0, FB_ADDRW'(e.addr), FB_ADDRW'(e.addr), DEPTH_WIDTH'(e.depth), COLR_WIDTH'(e.colr)});
    end else if (in_clear) begin
      if (bus.db_write_enable || bus.fb_write_enable) begin
        if (!(bus.db_write_enable && bus.fb_write_enable &&
              int'(bus.db_addr_write) == clr_next && int'(bus.fb_addr_write) == clr_next &&
              bus.db_data_write == 12'hFFF && bus.fb_data_write == 4'h0))
          clr_bad++;
        clr_next++;
        clr_writes++;
      end
      if (bus.clear_done) begin
        clr_done_seen++;
        clr_done_addr = int'(bus.db_addr_write);
      end
    end else begin
      check("idle_strobes", {61'd0, bus.db_write_enable, bus.fb_write_enable, bus.clear_done}, 64'd0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int a, input int d, input int c);
    bus.frag_valid = 1'b1;
    bus.frag_addr  = FB_ADDRW'(a);
    bus.frag_depth = DEPTH_WIDTH'(d);
    bus.frag_colr  = COLR_WIDTH'(c);
    #1;
    check("frag_ready", 64'(bus.frag_ready), 64'd1);
    check("db_addr_read", 64'(bus.db_addr_read), 64'(a));
    if (d < gdepth[a]) begin
      gdepth[a] = d;
      exp_wr.push_back('{cyc + 2, a, d, c});
      exp_pass++;
    end else begin
      exp_fail++;
    end
    tick();
    bus.frag_valid = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    check($sformatf("%s pass_count", tag), 64'(bus.pass_count), 64'(exp_pass));
    check($sformatf("%s fail_count", tag), 64'(bus.fail_count), 64'(exp_fail));
  endtask

  task automatic do_clear(input int stop_at, input bit junk);
    bus.clear_start = 1'b1;
    bus.frag_valid  = junk;
    bus.frag_addr   = FB_ADDRW'(3);
    bus.frag_depth  = '0;
    bus.frag_colr   = COLR_WIDTH'(9);
    #1;
    check("ready_low_on_clear_start", 64'(bus.frag_ready), 64'd0);
    in_clear      = 1'b1;
    clr_writes    = 0;
    clr_bad       = 0;
    clr_next      = 0;
    clr_done_seen = 0;
    clr_done_addr = -1;
    tick();
    bus.clear_start = 1'b0;
    bus.frag_valid  = 1'b0;
    check("busy_after_clear_start", 64'(bus.clear_busy), 64'd1);
    for (int i = 0; i < PIX + 100; i++) begin
      if (clr_done_seen > 0) break;
      if (stop_at >= 0 && bus.db_write_enable && clr_writes > 0 && int'(bus.db_addr_write) == stop_at) break;
      if (i == 3000) begin
        check("ready_low_while_busy", 64'(bus.frag_ready), 64'd0);
        bus.clear_start = 1'b1;
      end
      tick();
      bus.clear_start = 1'b0;
    end
    if (stop_at >= 0) begin
      check("reached_stop_addr", 64'(clr_writes), 64'(stop_at + 1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_clear = 1'b0;
      check("rst_outputs",
            {14'd0, bus.db_write_enable, bus.fb_write_enable, bus.clear_busy, bus.clear_done,
             bus.db_addr_write, bus.db_data_write, bus.fb_addr_write, bus.fb_data_write}, 64'd0);
      check("rst_counts", {bus.pass_count, bus.fail_count}, 64'd0);
      check("rst_ready", 64'(bus.frag_ready), 64'd1);
      exp_pass = 0;
      exp_fail = 0;
      for (int k = 0; k <= stop_at; k++) gdepth[k] = 4095;
    end else begin
      check("clear_done_pulses", 64'(clr_done_seen), 64'd1);
      check("clear_write_count", 64'(clr_writes), 64'(PIX));
      check("clear_bad_writes", 64'(clr_bad), 64'd0);
      check("clear_done_addr", 64'(clr_done_addr), 64'(PIX - 1));
      in_clear = 1'b0;
      tick();
      check("busy_low_after_done", 64'(bus.clear_busy), 64'd0);
      check("ready_after_clear", 64'(bus.frag_ready), 64'd1);
      exp_pass = 0;
      exp_fail = 0;
      check_counts("after_clear");
      for (int k = 0; k < PIX; k++) gdepth[k] = 4095;
    end
  endtask

  initial begin
    for (int k = 0; k < PIX; k++) begin
      db_mem[k] = '0;
      gdepth[k] = 0;
    end
    bus.frag_valid  = 1'b0;
    bus.frag_addr   = '0;
    bus.frag_depth  = '0;
    bus.frag_colr   = '0;
    bus.clear_start = 1'b0;

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("reset_outputs",
          {14'd0, bus.db_write_enable, bus.fb_write_enable, bus.clear_busy, bus.clear_done,
           bus.db_addr_write, bus.db_data_write, bus.fb_addr_write, bus.fb_data_write}, 64'd0);
    check("reset_counts", {bus.pass_count, bus.fail_count}, 64'd0);
    check("reset_ready", 64'(bus.frag_ready), 64'd1);

    do_clear(-1, 1'b0);

    send(500, 100, 7);
    idle(3);
    check_counts("basic");

    send(500, 100, 2);
    send(500, 99, 3);
    idle(3);
    check_counts("equal_reject");

    send(42, 200, 1);
    send(42, 300, 2);
    send(42, 150, 3);
    idle(3);
    check_counts("w1_forward");

    send(43, 200, 4);
    send(900, 50, 5);
    send(43, 250, 6);
    send(901, 60, 7);
    send(43, 180, 8);
    idle(3);
    check_counts("w2_forward");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(2000 + int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 15)));
    end
    idle(3);
    check_counts("random");

    send(10, 5, 1);
    send(11, 6, 2);
    do_clear(-1, 1'b1);

    send(5000, 10, 8);
    idle(3);
    check_counts("post_clear");

    do_clear(1000, 1'b0);

    send(5000, 20, 1);
    send(5000, 5, 2);
    idle(3);
    check_counts("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
